// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared definitions for the sequential divider.
// The 2-bit state encodings match those the ALU controller decodes, so keep
// the values fixed if states are ever added.
package seq_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_trial_sub.sv
// div_trial_sub: W-bit trial subtractor for the restoring divider.
// Ports:
//   x      in  W    partial remainder after shift
//   y      in  W    zero-extended divisor
//   diff   out W-1  low bits of x - y
//   borrow out 1    MSB of x - y; set when the trial subtraction went negative
module div_trial_sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-2:0] diff,
    output logic         borrow
);

    assign {borrow, diff} = x - y;

endmodule

// File: rtl/seq_div.sv
// seq_div: multi-cycle restoring divider, one quotient bit per clock.
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   request, accepted when not busy
//   a, b         in   dividend / divisor, sampled on the accepting edge
//   busy         out  iteration in progress
//   done         out  one-cycle pulse, results valid
//   quotient     out  held until the next operation completes
//   remainder    out  held until the next operation completes
//   div_by_zero  out  set with done when b == 0
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for start
// ST_RUN  | iterating, cnt_q counts down remaining iterations to zero
// ST_DONE | done pulse cycle; a new start is accepted here as in IDLE
module seq_div
    import seq_div_pkg::*;
#(
    parameter int N      = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  p_q, p_d;
    logic [N-1:0]  d_q, d_d;
    logic [N-1:0]  b_q, b_d;
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dbz_q, dbz_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;

    // Signed operands are reduced to magnitudes at load; -2^(N-1) maps to
    // 2^(N-1), which still fits as an unsigned N-bit magnitude.
    logic         a_neg, b_neg;
    logic [N-1:0] a_mag, b_mag;
    assign a_neg = SIGNED && a[N-1];
    assign b_neg = SIGNED && b[N-1];
    assign a_mag = a_neg ? (-a) : a;
    assign b_mag = b_neg ? (-b) : b;

    // The stored partial remainder is always < B, so only N bits are kept;
    // bit N of the shifted value comes back in through the subtractor.
    logic [N:0]   p_shift;
    logic [N-1:0] t_diff;
    logic         t_borrow;
    logic [N-1:0] p_next, d_next;

    assign p_shift = {p_q, d_q[N-1]};

    div_trial_sub #(.W(N + 1)) u_trial (
        .x      (p_shift),
        .y      ({1'b0, b_q}),
        .diff   (t_diff),
        .borrow (t_borrow)
    );

    assign p_next = t_borrow ? p_shift[N-1:0] : t_diff;
    assign d_next = {d_q[N-2:0], ~t_borrow};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        d_d     = d_q;
        b_d     = b_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    if (b == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        quot_d  = '1;
                        rem_d   = a;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                        cnt_d   = CW'(N - 1);
                        p_d     = '0;
                        d_d     = a_mag;
                        b_d     = b_mag;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                    end
                end
            end
            ST_RUN: begin
                p_d   = p_next;
                d_d   = d_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    dbz_d   = 1'b0;
                    quot_d  = qneg_q ? (-d_next) : d_next;
                    rem_d   = rneg_q ? (-p_next) : p_next;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            d_q     <= '0;
            b_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            d_q     <= d_d;
            b_q     <= b_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
module tb_seq_div;

    logic       clk;
    logic       rst_n;
    logic       st_u, st_s;
    logic [7:0] a, b;

    logic       du_busy, du_done, du_dbz;
    logic [7:0] du_q, du_r;
    logic       ds_busy, ds_done, ds_dbz;
    logic [7:0] ds_q, ds_r;

    int checks   = 0;
    int failures = 0;

    seq_div #(.N(8), .SIGNED(1'b0)) u_dut_u (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (st_u),
        .a           (a),
        .b           (b),
        .busy        (du_busy),
        .done        (du_done),
        .quotient    (du_q),
        .remainder   (du_r),
        .div_by_zero (du_dbz)
    );

    seq_div #(.N(8), .SIGNED(1'b1)) u_dut_s (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (st_s),
        .a           (a),
        .b           (b),
        .busy        (ds_busy),
        .done        (ds_done),
        .quotient    (ds_q),
        .remainder   (ds_r),
        .div_by_zero (ds_dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_done(input bit s);
        return s ? ds_done : du_done;
    endfunction

    function automatic logic get_busy(input bit s);
        return s ? ds_busy : du_busy;
    endfunction

    // Drive a request, let the next rising edge accept it, and return #1 after
    // that edge with start dropped.
    task automatic start_op(input bit s, input logic [7:0] aa, input logic [7:0] bb);
        a = aa;
        b = bb;
        if (s) st_s = 1'b1;
        else   st_u = 1'b1;
        @(posedge clk);
        #1;
        st_u = 1'b0;
        st_s = 1'b0;
    endtask

    // lat counts edges after the accepting edge until done is seen.
    task automatic wait_done(input bit s, input int lat0, output int lat, output bit busy_ok);
        lat     = lat0;
        busy_ok = 1'b1;
        while (!get_done(s) && lat < 40) begin
            if (!get_busy(s)) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    int lat;
    bit bok;
    int seen;

    initial begin
        rst_n = 1'b0;
        st_u  = 1'b0;
        st_s  = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        chk("rst_busy", {31'd0, du_busy}, 32'd0);
        chk("rst_done", {31'd0, du_done}, 32'd0);
        chk("rst_q", {24'd0, du_q}, 32'd0);
        chk("rst_r", {24'd0, du_r}, 32'd0);
        chk("rst_dbz", {31'd0, du_dbz}, 32'd0);
        chk("rst_s_q", {24'd0, ds_q}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 100 / 7 unsigned
        start_op(1'b0, 8'd100, 8'd7);
        chk("u100_busy_k", {31'd0, du_busy}, 32'd1);
        wait_done(1'b0, 0, lat, bok);
        chk("u100_lat", lat, 32'd8);
        chk("u100_busy_run", {31'd0, bok}, 32'd1);
        chk("u100_busy_at_done", {31'd0, du_busy}, 32'd0);
        chk("u100_q", {24'd0, du_q}, 32'd14);
        chk("u100_r", {24'd0, du_r}, 32'd2);
        chk("u100_dbz", {31'd0, du_dbz}, 32'd0);
        @(posedge clk);
        #1;
        chk("u100_done_pulse", {31'd0, du_done}, 32'd0);
        chk("u100_q_hold", {24'd0, du_q}, 32'd14);

        // 55 / 0 unsigned
        start_op(1'b0, 8'd55, 8'd0);
        chk("u_dz_busy", {31'd0, du_busy}, 32'd0);
        wait_done(1'b0, 0, lat, bok);
        chk("u_dz_lat", lat, 32'd0);
        chk("u_dz_q", {24'd0, du_q}, 32'hFF);
        chk("u_dz_r", {24'd0, du_r}, 32'd55);
        chk("u_dz_dbz", {31'd0, du_dbz}, 32'd1);
        @(posedge clk);
        #1;
        chk("u_dz_busy_after", {31'd0, du_busy}, 32'd0);
        chk("u_dz_done_pulse", {31'd0, du_done}, 32'd0);

        // -7 / 2 signed
        start_op(1'b1, 8'hF9, 8'h02);
        wait_done(1'b1, 0, lat, bok);
        chk("s_m7_lat", lat, 32'd8);
        chk("s_m7_q", {24'd0, ds_q}, 32'hFD);
        chk("s_m7_r", {24'd0, ds_r}, 32'hFF);
        @(posedge clk);
        #1;

        // -128 / -1 signed wraps
        start_op(1'b1, 8'h80, 8'hFF);
        wait_done(1'b1, 0, lat, bok);
        chk("s_min_q", {24'd0, ds_q}, 32'h80);
        chk("s_min_r", {24'd0, ds_r}, 32'h00);
        chk("s_min_dbz", {31'd0, ds_dbz}, 32'd0);
        @(posedge clk);
        #1;

        // 7 / -2 signed: remainder follows the dividend sign
        start_op(1'b1, 8'h07, 8'hFE);
        wait_done(1'b1, 0, lat, bok);
        chk("s_7m2_q", {24'd0, ds_q}, 32'hFD);
        chk("s_7m2_r", {24'd0, ds_r}, 32'h01);
        @(posedge clk);
        #1;

        // -128 / 0 signed
        start_op(1'b1, 8'h80, 8'h00);
        wait_done(1'b1, 0, lat, bok);
        chk("s_dz_lat", lat, 32'd0);
        chk("s_dz_q", {24'd0, ds_q}, 32'hFF);
        chk("s_dz_r", {24'd0, ds_r}, 32'h80);
        chk("s_dz_dbz", {31'd0, ds_dbz}, 32'd1);
        @(posedge clk);
        #1;

        // 255 / 1 and 5 / 9 unsigned boundaries
        start_op(1'b0, 8'd255, 8'd1);
        wait_done(1'b0, 0, lat, bok);
        chk("u255_q", {24'd0, du_q}, 32'd255);
        chk("u255_r", {24'd0, du_r}, 32'd0);
        @(posedge clk);
        #1;
        start_op(1'b0, 8'd5, 8'd9);
        wait_done(1'b0, 0, lat, bok);
        chk("u5_9_q", {24'd0, du_q}, 32'd0);
        chk("u5_9_r", {24'd0, du_r}, 32'd5);
        @(posedge clk);
        #1;

        // start while busy is ignored
        start_op(1'b0, 8'd100, 8'd7);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("ign_q_held", {24'd0, du_q}, 32'd0);
        chk("ign_r_held", {24'd0, du_r}, 32'd5);
        start_op(1'b0, 8'd9, 8'd3);
        a = 8'd0;
        b = 8'd0;
        wait_done(1'b0, 3, lat, bok);
        chk("ign_lat", lat, 32'd8);
        chk("ign_busy_run", {31'd0, bok}, 32'd1);
        chk("ign_q", {24'd0, du_q}, 32'd14);
        chk("ign_r", {24'd0, du_r}, 32'd2);

        // back-to-back: start held in the DONE cycle
        @(posedge clk);
        #1;
        start_op(1'b0, 8'd100, 8'd7);
        wait_done(1'b0, 0, lat, bok);
        chk("b2b_first_q", {24'd0, du_q}, 32'd14);
        start_op(1'b0, 8'd9, 8'd3);
        chk("b2b_busy", {31'd0, du_busy}, 32'd1);
        chk("b2b_done_low", {31'd0, du_done}, 32'd0);
        wait_done(1'b0, 0, lat, bok);
        chk("b2b_lat", lat, 32'd8);
        chk("b2b_q", {24'd0, du_q}, 32'd3);
        chk("b2b_r", {24'd0, du_r}, 32'd0);
        @(posedge clk);
        #1;

        // reset mid-RUN
        start_op(1'b0, 8'd100, 8'd7);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", {31'd0, du_busy}, 32'd0);
        chk("mrst_done", {31'd0, du_done}, 32'd0);
        chk("mrst_q", {24'd0, du_q}, 32'd0);
        chk("mrst_r", {24'd0, du_r}, 32'd0);
        chk("mrst_dbz", {31'd0, du_dbz}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (du_done || du_busy) seen++;
        end
        chk("mrst_no_done", seen, 32'd0);
        start_op(1'b0, 8'd20, 8'd6);
        wait_done(1'b0, 0, lat, bok);
        chk("post_rst_lat", lat, 32'd8);
        chk("post_rst_q", {24'd0, du_q}, 32'd3);
        chk("post_rst_r", {24'd0, du_r}, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
